// File: rtl/vga_sync_interface.sv
// 640x480@60 VGA timing generator: pixel counters, scan address to the compositor,
// and registered colour/sync/refresh outputs advanced by the DOWNCOUNTER pixel enable.
module vga_sync_interface #(
  parameter int          H_VISIBLE   = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_VISIBLE   = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter logic [11:0] BLANK_COLOR = 12'h000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DOWNCOUNTER,
  input  logic [11:0] COLOR_IN,
  output logic [11:0] COLOR_OUT,
  output logic        HS,
  output logic        VS,
  output logic        REFRESH,
  output logic [9:0]  ADDRH,
  output logic [8:0]  ADDRV
);

  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       vis;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_active;
  logic       vs_active;

  assign vis       = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign h_wrap    = (h_cnt == H_LAST);
  assign v_wrap    = (v_cnt == V_LAST);
  assign hs_active = (h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END);
  assign vs_active = (v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END);

  // Sentinel all-ones addresses lie outside every region the compositor paints.
  assign ADDRH = vis ? h_cnt : 10'h3FF;
  assign ADDRV = vis ? v_cnt[8:0] : 9'h1FF;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      COLOR_OUT <= 12'h000;
      HS        <= 1'b1;
      VS        <= 1'b1;
      REFRESH   <= 1'b0;
    end else if (DOWNCOUNTER) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
      // Outputs follow the pre-increment position, one tick behind ADDRH/ADDRV.
      COLOR_OUT <= vis ? COLOR_IN : BLANK_COLOR;
      HS        <= ~hs_active;
      VS        <= ~vs_active;
      REFRESH   <= h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_interface.sv
// Randomised bench for vga_sync_interface: full-size timing instance plus a shrunken
// geometry instance so whole frames fit in a short run; both checked against a tick-count model.
module tb_vga_sync_interface;

  typedef struct {
    int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp;
  } geo_t;

  typedef struct {
    logic [11:0] color;
    logic        hs, vs, refresh;
  } regs_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        DOWNCOUNTER;
  logic [11:0] COLOR_IN;

  logic [11:0] a_color, b_color;
  logic        a_hs, a_vs, a_ref, b_hs, b_vs, b_ref;
  logic [9:0]  a_addrh, b_addrh;
  logic [8:0]  a_addrv, b_addrv;

  int n_vec = 0;
  int n_miscmp = 0;

  geo_t  ga, gb;
  int    ta, tb;
  regs_t ea, eb;

  int   a_hs_fall = -1, b_vs_fall = -1, b_ref_last = -1;
  logic prev_a_hs = 1'b1, prev_b_vs = 1'b1, prev_b_ref = 1'b0;

  vga_sync_interface u_full (
    .CLK(CLK), .RST(RST), .DOWNCOUNTER(DOWNCOUNTER), .COLOR_IN(COLOR_IN),
    .COLOR_OUT(a_color), .HS(a_hs), .VS(a_vs), .REFRESH(a_ref),
    .ADDRH(a_addrh), .ADDRV(a_addrv)
  );

  vga_sync_interface #(
    .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(5),  .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_small (
    .CLK(CLK), .RST(RST), .DOWNCOUNTER(DOWNCOUNTER), .COLOR_IN(COLOR_IN),
    .COLOR_OUT(b_color), .HS(b_hs), .VS(b_vs), .REFRESH(b_ref),
    .ADDRH(b_addrh), .ADDRV(b_addrv)
  );

  always #10 CLK = ~CLK;

  function automatic int h_total(geo_t g);
    return g.hv + g.hfp + g.hsw + g.hbp;
  endfunction

  function automatic int v_total(geo_t g);
    return g.vv + g.vfp + g.vsw + g.vbp;
  endfunction

  function automatic logic [9:0] exp_addrh(geo_t g, int t);
    int h = t % h_total(g);
    int v = (t / h_total(g)) % v_total(g);
    return (h < g.hv && v < g.vv) ? h[9:0] : 10'h3FF;
  endfunction

  function automatic logic [8:0] exp_addrv(geo_t g, int t);
    int h = t % h_total(g);
    int v = (t / h_total(g)) % v_total(g);
    return (h < g.hv && v < g.vv) ? v[8:0] : 9'h1FF;
  endfunction

  // Output registers produced by a tick taken at scan position t.
  function automatic regs_t step(geo_t g, int t, logic [11:0] cin);
    regs_t r;
    int h = t % h_total(g);
    int v = (t / h_total(g)) % v_total(g);
    r.color   = (h < g.hv && v < g.vv) ? cin : 12'h000;
    r.hs      = !(h >= g.hv + g.hfp && h < g.hv + g.hfp + g.hsw);
    r.vs      = !(v >= g.vv + g.vfp && v < g.vv + g.vfp + g.vsw);
    r.refresh = (h == h_total(g) - 1) && (v == v_total(g) - 1);
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ta = 0;
      tb = 0;
      ea = '{12'h000, 1'b1, 1'b1, 1'b0};
      eb = '{12'h000, 1'b1, 1'b1, 1'b0};
    end else if (DOWNCOUNTER) begin
      ea = step(ga, ta, COLOR_IN);
      eb = step(gb, tb, COLOR_IN);
      ta = ta + 1;
      tb = tb + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("a_addrh", a_addrh, exp_addrh(ga, ta));
    check("a_addrv", a_addrv, exp_addrv(ga, ta));
    check("a_color", a_color, ea.color);
    check("a_hs", a_hs, ea.hs);
    check("a_vs", a_vs, ea.vs);
    check("a_refresh", a_ref, ea.refresh);
    check("b_addrh", b_addrh, exp_addrh(gb, tb));
    check("b_addrv", b_addrv, exp_addrv(gb, tb));
    check("b_color", b_color, eb.color);
    check("b_hs", b_hs, eb.hs);
    check("b_vs", b_vs, eb.vs);
    check("b_refresh", b_ref, eb.refresh);
    // Interval measurements in ticks, taken from the DUT's own edges.
    if (prev_a_hs && !a_hs) begin
      if (a_hs_fall >= 0) check("hs_line_period", ta - a_hs_fall, 800);
      a_hs_fall = ta;
    end
    if (!prev_a_hs && a_hs && a_hs_fall >= 0) check("hs_width", ta - a_hs_fall, 96);
    if (prev_b_vs && !b_vs) begin
      if (b_vs_fall >= 0) check("vs_frame_period", tb - b_vs_fall, h_total(gb) * v_total(gb));
      b_vs_fall = tb;
    end
    if (!prev_b_vs && b_vs && b_vs_fall >= 0) check("vs_width", tb - b_vs_fall, gb.vsw * h_total(gb));
    if (!prev_b_ref && b_ref) begin
      check("refresh_addrh0", b_addrh, 0);
      check("refresh_addrv0", b_addrv, 0);
      if (b_ref_last >= 0) check("refresh_period", tb - b_ref_last, h_total(gb) * v_total(gb));
      b_ref_last = tb;
    end
    prev_a_hs  = a_hs;
    prev_b_vs  = b_vs;
    prev_b_ref = b_ref;
  endtask

  task automatic drive_rand();
    DOWNCOUNTER = 1'($urandom_range(0, 1));
    COLOR_IN    = 12'($urandom);
  endtask

  initial begin
    int n;
    ga = '{640, 16, 96, 48, 480, 10, 2, 33};
    gb = '{10, 2, 3, 2, 5, 1, 2, 1};
    DOWNCOUNTER = 1'b0;
    COLOR_IN    = 12'h000;
    RST         = 1'b1;
    repeat (3) @(negedge CLK);
    check_all();
    RST         = 1'b0;
    DOWNCOUNTER = 1'b1;
    COLOR_IN    = 12'hABC;
    @(negedge CLK);
    check("first_pixel_color", a_color, 12'hABC);
    check_all();

    // Toggled enable: ADDRH advances once every two CLKs.
    repeat (20) begin
      DOWNCOUNTER = ~DOWNCOUNTER;
      COLOR_IN    = 12'($urandom);
      @(negedge CLK);
      check_all();
    end

    repeat (4000) begin
      drive_rand();
      @(negedge CLK);
      check_all();
    end

    // Park at column 300 of some visible line, then freeze.
    n = 0;
    while ((ta % 800) != 300 && n < 3000) begin
      drive_rand();
      @(negedge CLK);
      check_all();
      n++;
    end
    if ((ta % 800) != 300) check("wait_h300_timeout", a_addrh, 300);
    DOWNCOUNTER = 1'b0;
    repeat (50) begin
      COLOR_IN = 12'($urandom);
      @(negedge CLK);
      check_all();
      check("hold_addrh", a_addrh, 300);
    end
    DOWNCOUNTER = 1'b1;
    @(negedge CLK);
    check_all();
    check("resume_addrh", a_addrh, 301);

    // Asynchronous mid-frame reset, asserted between clock edges.
    repeat (37) begin
      drive_rand();
      @(negedge CLK);
      check_all();
    end
    #3;
    a_hs_fall  = -1;
    b_vs_fall  = -1;
    b_ref_last = -1;
    RST = 1'b1;
    #1;
    check_all();
    check("rst_hs", a_hs, 1);
    check("rst_vs", a_vs, 1);
    check("rst_color", a_color, 0);
    check("rst_refresh", a_ref, 0);
    check("rst_addrh", a_addrh, 0);
    check("rst_addrv", a_addrv, 0);
    @(negedge CLK);
    check_all();
    RST = 1'b0;

    // Continuous enable: a tick every CLK.
    DOWNCOUNTER = 1'b1;
    repeat (2000) begin
      COLOR_IN = 12'($urandom);
      @(negedge CLK);
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
